// File: rtl/asip_pkg.sv
// Shared types for the memory-access stage.
// Contents: FSM state enum, register-index width, and the decoded mem-op struct.
package asip_pkg;

  localparam int unsigned REG_IDX_W = 4;

  typedef enum logic [0:0] {
    MEM_IDLE,
    MEM_ACCESS
  } mem_state_t;

  typedef struct packed {
    logic read;
    logic write;
  } mem_op_t;

  // Read and write both set is illegal; it is resolved as a load.
  function automatic mem_op_t decode_mem_op(input logic rd, input logic wr);
    mem_op_t op;
    op.read  = rd;
    op.write = wr & ~rd;
    return op;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Bundle of execute-side, data-memory and writeback signals for mem_access_stage.
// Modports:
//   master - the memory stage: consumes ex_*/flush/mem_rdata/mem_ack and drives stall,
//            mem_req/we/addr/wdata, wb_* and mem_error.
//   slave  - the environment (execute stage, data memory, writeback) on the other side.
interface mem_access_stage_if #(
  parameter int unsigned dataSize = 8,
  parameter int unsigned addrSize = 8
);
  import asip_pkg::*;

  logic                 ex_valid;
  logic [dataSize-1:0]  ex_result;
  logic [dataSize-1:0]  ex_store_data;
  logic                 ex_mem_read;
  logic                 ex_mem_write;
  logic [REG_IDX_W-1:0] ex_rd;
  logic                 ex_reg_write;
  logic                 ex_neg_flag;
  logic                 ex_zero_flag;
  logic                 flush;
  logic                 stall;

  logic                 mem_req;
  logic                 mem_we;
  logic [addrSize-1:0]  mem_addr;
  logic [dataSize-1:0]  mem_wdata;
  logic [dataSize-1:0]  mem_rdata;
  logic                 mem_ack;

  logic                 wb_valid;
  logic [dataSize-1:0]  wb_data;
  logic [REG_IDX_W-1:0] wb_rd;
  logic                 wb_reg_write;
  logic                 wb_neg_flag;
  logic                 wb_zero_flag;
  logic                 mem_error;

  modport master (
    input  ex_valid, ex_result, ex_store_data, ex_mem_read, ex_mem_write, ex_rd,
           ex_reg_write, ex_neg_flag, ex_zero_flag, flush, mem_rdata, mem_ack,
    output stall, mem_req, mem_we, mem_addr, mem_wdata,
           wb_valid, wb_data, wb_rd, wb_reg_write, wb_neg_flag, wb_zero_flag, mem_error
  );

  modport slave (
    output ex_valid, ex_result, ex_store_data, ex_mem_read, ex_mem_write, ex_rd,
           ex_reg_write, ex_neg_flag, ex_zero_flag, flush, mem_rdata, mem_ack,
    input  stall, mem_req, mem_we, mem_addr, mem_wdata,
           wb_valid, wb_data, wb_rd, wb_reg_write, wb_neg_flag, wb_zero_flag, mem_error
  );

endinterface

// File: rtl/mem_access_stage_timer.sv
// mem_wait_timer: counts ACCESS cycles without an ack.
// Ports: clk, rst_n (async active-low), i_clear (sync clear), i_enable (count this cycle),
//        o_tc (this enabled cycle is the MAX_WAIT-th one; the access must be abandoned).
module mem_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(MAX_WAIT - 1);

  logic [CntW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CntW'(1);
    end
  end

  // Fires while the count is one short so the edge that would reach MAX_WAIT ends the access.
  assign o_tc = i_enable && (r_count == LastCnt);

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory stage after the ALU. Non-memory ops pass to writeback in one cycle;
// loads/stores are captured, issued over a req/ack bus while stalling upstream, and abandoned
// with a mem_error pulse after MAX_WAIT unacknowledged cycles.
// Ports: clk, rst_n (async active-low), io_bus (mem_access_stage_if.master: ex_*, flush, stall,
//        mem_* bus, wb_* outputs, mem_error).
module mem_access_stage
  import asip_pkg::*;
#(
  parameter int unsigned dataSize = 8,
  parameter int unsigned addrSize = 8,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_access_stage_if.master  io_bus
);

  mem_state_t r_state, w_state_next;

  mem_op_t              r_op;
  logic [dataSize-1:0]  r_result;
  logic [REG_IDX_W-1:0] r_rd;
  logic                 r_reg_write, r_neg, r_zero, r_kill;
  logic [addrSize-1:0]  r_mem_addr;
  logic [dataSize-1:0]  r_mem_wdata;

  logic                 r_wb_valid, r_wb_reg_write, r_wb_neg, r_wb_zero, r_mem_error;
  logic [dataSize-1:0]  r_wb_data;
  logic [REG_IDX_W-1:0] r_wb_rd;

  mem_op_t w_op;
  logic    w_is_mem, w_capture, w_pass, w_done, w_timeout, w_stall, w_tc, w_tmr_en;

  assign w_op     = decode_mem_op(io_bus.ex_mem_read, io_bus.ex_mem_write);
  assign w_is_mem = w_op.read | w_op.write;
  assign w_tmr_en = (r_state == MEM_ACCESS) && !io_bus.mem_ack;

  mem_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_capture),
    .i_enable(w_tmr_en),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= MEM_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_capture    = 1'b0;
    w_pass       = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    unique case (r_state)
      MEM_IDLE: begin
        if (io_bus.ex_valid && !io_bus.flush) begin
          if (w_is_mem) begin
            w_capture    = 1'b1;
            w_stall      = 1'b1;
            w_state_next = MEM_ACCESS;
          end else begin
            w_pass = 1'b1;
          end
        end
      end
      MEM_ACCESS: begin
        // Upstream advances on the ack edge, so stall drops in that cycle only.
        w_stall = !io_bus.mem_ack;
        if (io_bus.mem_ack) begin
          w_done       = 1'b1;
          w_state_next = MEM_IDLE;
        end else if (w_tc) begin
          w_timeout    = 1'b1;
          w_state_next = MEM_IDLE;
        end
      end
      default: w_state_next = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op           <= '0;
      r_result       <= '0;
      r_rd           <= '0;
      r_reg_write    <= 1'b0;
      r_neg          <= 1'b0;
      r_zero         <= 1'b0;
      r_kill         <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_wb_valid     <= 1'b0;
      r_wb_data      <= '0;
      r_wb_rd        <= '0;
      r_wb_reg_write <= 1'b0;
      r_wb_neg       <= 1'b0;
      r_wb_zero      <= 1'b0;
      r_mem_error    <= 1'b0;
    end else begin
      r_wb_valid  <= 1'b0;
      r_mem_error <= w_timeout;
      if (w_capture) begin
        r_op        <= w_op;
        r_result    <= io_bus.ex_result;
        r_rd        <= io_bus.ex_rd;
        r_reg_write <= io_bus.ex_reg_write;
        r_neg       <= io_bus.ex_neg_flag;
        r_zero      <= io_bus.ex_zero_flag;
        r_kill      <= 1'b0;
        // Truncates or zero-extends the ALU result to the bus address width.
        r_mem_addr  <= addrSize'(io_bus.ex_result);
        r_mem_wdata <= io_bus.ex_store_data;
      end else if ((r_state == MEM_ACCESS) && io_bus.flush) begin
        r_kill <= 1'b1;
      end
      if (w_pass) begin
        r_wb_valid     <= 1'b1;
        r_wb_data      <= io_bus.ex_result;
        r_wb_rd        <= io_bus.ex_rd;
        r_wb_reg_write <= io_bus.ex_reg_write;
        r_wb_neg       <= io_bus.ex_neg_flag;
        r_wb_zero      <= io_bus.ex_zero_flag;
      end
      // A flush in the ack cycle itself also kills the result.
      if (w_done && !(r_kill || io_bus.flush)) begin
        r_wb_valid <= 1'b1;
        r_wb_rd    <= r_rd;
        if (r_op.read) begin
          r_wb_data      <= io_bus.mem_rdata;
          r_wb_zero      <= (io_bus.mem_rdata == '0);
          r_wb_neg       <= io_bus.mem_rdata[dataSize-1];
          r_wb_reg_write <= r_reg_write;
        end else begin
          r_wb_data      <= r_result;
          r_wb_zero      <= r_zero;
          r_wb_neg       <= r_neg;
          r_wb_reg_write <= 1'b0;
        end
      end
    end
  end

  assign io_bus.stall        = rst_n & w_stall;
  assign io_bus.mem_req      = (r_state == MEM_ACCESS);
  assign io_bus.mem_we       = (r_state == MEM_ACCESS) & r_op.write;
  assign io_bus.mem_addr     = r_mem_addr;
  assign io_bus.mem_wdata    = r_mem_wdata;
  assign io_bus.wb_valid     = r_wb_valid;
  assign io_bus.wb_data      = r_wb_data;
  assign io_bus.wb_rd        = r_wb_rd;
  assign io_bus.wb_reg_write = r_wb_reg_write;
  assign io_bus.wb_neg_flag  = r_wb_neg;
  assign io_bus.wb_zero_flag = r_wb_zero;
  assign io_bus.mem_error    = r_mem_error;

endmodule
